// File: rtl/mt_regfile_ctx.sv
// Multi-thread X/Y/A/S register file with power-on init sweep,
// thread-context copy engine and sticky per-thread stack wrap flags.
module mt_regfile_ctx #(
   parameter int DW     = 8,
   parameter int NTHR   = 8,
   parameter int INIT_A = 'h40,
   parameter int CPU_ID = 'h38,
   localparam int TW    = $clog2(NTHR)
) (
   input  logic          clk,
   input  logic          RST_n,
   input  logic [TW-1:0] reg_thr,
   input  logic [1:0]    reg_src,
   input  logic [1:0]    reg_idx,
   input  logic [1:0]    reg_dst,
   input  logic          reg_we,
   input  logic [DW-1:0] dst,
   output logic [DW-1:0] src,
   output logic [DW-1:0] idx,
   output logic [DW-1:0] sp,
   input  logic          txs,
   input  logic          push,
   input  logic          pull,
   input  logic          variation,
   input  logic          stk_clr,
   output logic          stk_ovf,
   output logic          stk_unf,
   input  logic          fork_req,
   input  logic [TW-1:0] fork_from,
   input  logic [TW-1:0] fork_to,
   output logic          busy,
   output logic          fork_done
);

   typedef enum logic [1:0] {
      S_INIT,
      S_IDLE,
      S_COPY
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [TW-1:0]     r_cnt;
   logic [1:0]        r_cc;
   logic [TW-1:0]     r_from;
   logic [TW-1:0]     r_to;
   logic              r_done;

   logic [DW-1:0]     r_x [NTHR];
   logic [DW-1:0]     r_y [NTHR];
   logic [DW-1:0]     r_a [NTHR];
   logic [DW-1:0]     r_s [NTHR];
   logic [NTHR-1:0]   r_ovf;
   logic [NTHR-1:0]   r_unf;

   logic              w_init;
   logic              w_core;
   logic              w_cp;
   logic [NTHR-1:0]   w_sel;
   logic [NTHR-1:0]   w_cpd;

   assign w_init = RST_n && (r_state == S_INIT);
   assign w_core = RST_n && (r_state != S_INIT);
   assign w_cp   = RST_n && (r_state == S_COPY);

   // next-state logic: sweep all threads, then serve fork copies
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_INIT:  if (r_cnt == TW'(NTHR - 1)) w_state_nxt = S_IDLE;
         S_IDLE:  if (fork_req) w_state_nxt = S_COPY;
         S_COPY:  if (r_cc == 2'd3) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_INIT;
      endcase
   end

   // state register, sweep/copy counters, latched fork threads
   always_ff @(posedge clk) begin
      if (!RST_n) begin
         r_state <= S_INIT;
         r_cnt   <= '0;
         r_cc    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= (r_state == S_COPY) && (r_cc == 2'd3);
         if (r_state == S_INIT) r_cnt <= r_cnt + 1'b1;
         r_cc <= (r_state == S_COPY) ? r_cc + 2'd1 : 2'd0;
         if (r_state == S_IDLE && fork_req) begin
            r_from <= fork_from;
            r_to   <= fork_to;
         end
      end
   end

   // per-thread decode of core-port target and copy destination
   always_comb begin
      w_sel = '0;
      w_cpd = '0;
      for (int t = 0; t < NTHR; t++) begin
         w_sel[t] = w_core && (reg_thr == TW'(t));
         w_cpd[t] = w_cp && (r_to == TW'(t));
      end
   end

   // register contents: init sweep, else copy > core ops
   always_ff @(posedge clk) begin
      for (int t = 0; t < NTHR; t++) begin
         if (w_init && (r_cnt == TW'(t))) begin
            r_x[t]   <= DW'(1 + t);
            r_y[t]   <= DW'(2 + 2 * t);
            r_a[t]   <= DW'(INIT_A + t);
            r_s[t]   <= '1;
            r_ovf[t] <= 1'b0;
            r_unf[t] <= 1'b0;
         end else begin
            if (w_cpd[t] && r_cc == 2'd0)
               r_x[t] <= r_x[r_from];
            else if (w_sel[t] && reg_we && reg_dst == 2'd0)
               r_x[t] <= dst;

            if (w_cpd[t] && r_cc == 2'd1)
               r_y[t] <= r_y[r_from];
            else if (w_sel[t] && reg_we && reg_dst == 2'd1)
               r_y[t] <= dst;

            if (w_cpd[t] && r_cc == 2'd2)
               r_a[t] <= r_a[r_from];
            else if (w_sel[t] && variation)
               r_a[t] <= DW'(CPU_ID);
            else if (w_sel[t] && reg_we && reg_dst == 2'd2)
               r_a[t] <= dst;

            if (w_cpd[t] && r_cc == 2'd3)
               r_s[t] <= r_s[r_from];
            else if (w_sel[t] && txs)
               r_s[t] <= src;
            else if (w_sel[t] && push)
               r_s[t] <= r_s[t] - 1'b1;
            else if (w_sel[t] && pull)
               r_s[t] <= r_s[t] + 1'b1;

            if (w_sel[t] && !(w_cpd[t] && r_cc == 2'd3) && !txs &&
                push && r_s[t] == '0)
               r_ovf[t] <= 1'b1;
            else if (w_sel[t] && stk_clr)
               r_ovf[t] <= 1'b0;

            if (w_sel[t] && !(w_cpd[t] && r_cc == 2'd3) && !txs &&
                !push && pull && r_s[t] == '1)
               r_unf[t] <= 1'b1;
            else if (w_sel[t] && stk_clr)
               r_unf[t] <= 1'b0;
         end
      end
   end

   // combinational read ports of the selected thread
   always_comb begin
      src = '0;
      idx = '0;
      case (reg_src)
         2'd0:    src = r_x[reg_thr];
         2'd1:    src = r_y[reg_thr];
         2'd2:    src = r_a[reg_thr];
         default: src = '0;
      endcase
      case (reg_idx)
         2'd0:    idx = r_x[reg_thr];
         2'd1:    idx = r_y[reg_thr];
         2'd2:    idx = r_a[reg_thr];
         default: idx = '0;
      endcase
   end

   assign sp        = r_s[reg_thr];
   assign stk_ovf   = r_ovf[reg_thr];
   assign stk_unf   = r_unf[reg_thr];
   assign busy      = (r_state != S_IDLE);
   assign fork_done = r_done;

endmodule

// File: tb/tb_mt_regfile_ctx.sv
// Scoreboard bench for mt_regfile_ctx: model of all thread contexts,
// expected reads queued on drive and popped when outputs settle.
module tb_mt_regfile_ctx;

   localparam int NT = 8;

   logic       clk = 1'b0;
   logic       RST_n;
   logic [2:0] reg_thr, fork_from, fork_to;
   logic [1:0] reg_src, reg_idx, reg_dst;
   logic       reg_we, txs, push, pull, variation, stk_clr, fork_req;
   logic [7:0] dst, src, idx, sp;
   logic       stk_ovf, stk_unf, busy, fork_done;
   logic [15:0] dst16, src16, idx16, sp16;
   logic       ovf16, unf16, busy16, done16;

   assign dst16 = {8'h00, dst};

   mt_regfile_ctx u_dut (
      .clk(clk), .RST_n(RST_n), .reg_thr(reg_thr),
      .reg_src(reg_src), .reg_idx(reg_idx), .reg_dst(reg_dst),
      .reg_we(reg_we), .dst(dst), .src(src), .idx(idx), .sp(sp),
      .txs(txs), .push(push), .pull(pull), .variation(variation),
      .stk_clr(stk_clr), .stk_ovf(stk_ovf), .stk_unf(stk_unf),
      .fork_req(fork_req), .fork_from(fork_from), .fork_to(fork_to),
      .busy(busy), .fork_done(fork_done)
   );

   mt_regfile_ctx #(.DW(16)) u_dut16 (
      .clk(clk), .RST_n(RST_n), .reg_thr(reg_thr),
      .reg_src(reg_src), .reg_idx(reg_idx), .reg_dst(reg_dst),
      .reg_we(reg_we), .dst(dst16), .src(src16), .idx(idx16), .sp(sp16),
      .txs(txs), .push(push), .pull(pull), .variation(variation),
      .stk_clr(stk_clr), .stk_ovf(ovf16), .stk_unf(unf16),
      .fork_req(fork_req), .fork_from(fork_from), .fork_to(fork_to),
      .busy(busy16), .fork_done(done16)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   logic [7:0] mx [NT];
   logic [7:0] my [NT];
   logic [7:0] ma [NT];
   logic [7:0] ms [NT];

   string       q_t [$];
   logic [31:0] q_v [$];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] v);
      q_t.push_back(tag);
      q_v.push_back(v);
   endtask

   task automatic sb_pop(input logic [31:0] got);
      string       t;
      logic [31:0] v;
      if (q_v.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         t = q_t.pop_front();
         v = q_v.pop_front();
         check(t, got, v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] msel(input int t, input int s);
      case (s)
         0:       return mx[t];
         1:       return my[t];
         2:       return ma[t];
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_init();
      for (int t = 0; t < NT; t++) begin
         mx[t] = 8'(1 + t);
         my[t] = 8'(2 + 2 * t);
         ma[t] = 8'('h40 + t);
         ms[t] = 8'hFF;
      end
   endtask

   task automatic probe(input int t);
      reg_thr = 3'(t);
      for (int r = 0; r < 4; r++) begin
         reg_src = 2'(r);
         reg_idx = 2'(3 - r);
         sb_push($sformatf("T%0d.src%0d", t, r), 32'(msel(t, r)));
         sb_push($sformatf("T%0d.idx%0d", t, 3 - r), 32'(msel(t, 3 - r)));
         #1;
         sb_pop(32'(src));
         sb_pop(32'(idx));
      end
      sb_push($sformatf("T%0d.sp", t), 32'(ms[t]));
      #1;
      sb_pop(32'(sp));
      reg_src = 2'd0;
      reg_idx = 2'd0;
   endtask

   task automatic wr(input int t, input int d, input logic [7:0] v);
      reg_thr = 3'(t);
      reg_dst = 2'(d);
      dst     = v;
      reg_we  = 1'b1;
      tick();
      reg_we  = 1'b0;
      case (d)
         0: mx[t] = v;
         1: my[t] = v;
         2: ma[t] = v;
         default: ;
      endcase
   endtask

   task automatic stk_op(input int t, input bit p, input bit l,
                         input bit c);
      reg_thr = 3'(t);
      push    = p;
      pull    = l;
      stk_clr = c;
      tick();
      push    = 1'b0;
      pull    = 1'b0;
      stk_clr = 1'b0;
      if (p) ms[t] = ms[t] - 8'd1;
      else if (l) ms[t] = ms[t] + 8'd1;
   endtask

   task automatic run_fork(input int f, input int d, input bit coll);
      int n;
      fork_from = 3'(f);
      fork_to   = 3'(d);
      fork_req  = 1'b1;
      tick();
      fork_req  = 1'b0;
      n = 0;
      while (busy && n < 20) begin
         if (coll && n == 0) begin
            reg_thr = 3'(d);
            reg_dst = 2'd0;
            dst     = 8'h77;
            reg_we  = 1'b1;
         end
         if (coll && n == 1) reg_thr = 3'(d + 1);
         if (coll && n == 2) reg_we = 1'b0;
         if (fork_done) check("done_early", 32'(fork_done), 32'd0);
         tick();
         n++;
      end
      reg_we = 1'b0;
      check("fork_len", 32'(n), 32'd4);
      check("fork_done", 32'(fork_done), 32'd1);
      mx[d] = mx[f];
      my[d] = my[f];
      ma[d] = ma[f];
      ms[d] = ms[f];
      if (coll) mx[d + 1] = 8'h77;
      tick();
      check("done_pulse", 32'(fork_done), 32'd0);
   endtask

   task automatic sweep(input bit junk);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      if (junk) begin
         reg_thr  = 3'd0;
         reg_dst  = 2'd0;
         dst      = 8'hAA;
         reg_we   = 1'b1;
         push     = 1'b1;
         fork_req = 1'b1;
      end
      while (busy && n < 50) begin
         if (fork_done) seen = 1'b1;
         tick();
         n++;
      end
      reg_we   = 1'b0;
      push     = 1'b0;
      fork_req = 1'b0;
      check("init_len", 32'(n), 32'(NT));
      check("init_nodone", 32'(seen), 32'd0);
      model_init();
   endtask

   initial begin
      RST_n = 1'b0;
      reg_thr = '0; fork_from = '0; fork_to = '0;
      reg_src = '0; reg_idx = '0; reg_dst = '0;
      reg_we = 1'b0; txs = 1'b0; push = 1'b0; pull = 1'b0;
      variation = 1'b0; stk_clr = 1'b0; fork_req = 1'b0;
      dst = '0;
      repeat (3) tick();
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_done", 32'(fork_done), 32'd0);
      RST_n = 1'b1;
      sweep(1'b0);
      check("busy16", 32'(busy16), 32'd0);
      probe(3);
      probe(0);

      wr(2, 0, 8'hF0);
      reg_thr = 3'd2; reg_src = 2'd0; txs = 1'b1;
      tick();
      txs = 1'b0;
      ms[2] = 8'hF0;
      wr(2, 0, 8'h11);
      wr(2, 1, 8'h22);
      wr(2, 2, 8'h33);
      wr(0, 3, 8'hAB);
      probe(0);
      run_fork(2, 5, 1'b0);
      probe(5);
      probe(2);

      wr(2, 0, 8'h44);
      run_fork(2, 5, 1'b1);
      probe(5);
      probe(6);

      wr(1, 0, 8'h00);
      reg_thr = 3'd1; reg_src = 2'd0; txs = 1'b1;
      tick();
      txs = 1'b0;
      ms[1] = 8'h00;
      stk_op(1, 1'b1, 1'b0, 1'b0);
      check("push_sp", 32'(sp), 32'hFF);
      check("push_ovf", 32'(stk_ovf), 32'd1);
      check("push16_sp", 32'(sp16), 32'hFFFF);
      check("push16_ovf", 32'(ovf16), 32'd1);
      stk_op(1, 1'b0, 1'b1, 1'b0);
      check("pull_sp", 32'(sp), 32'h00);
      check("pull_unf", 32'(stk_unf), 32'd1);
      check("pull_ovf", 32'(stk_ovf), 32'd1);
      stk_op(4, 1'b0, 1'b1, 1'b0);
      check("t4_unf", 32'(stk_unf), 32'd1);
      stk_op(1, 1'b0, 1'b0, 1'b1);
      check("clr_ovf", 32'(stk_ovf), 32'd0);
      check("clr_unf", 32'(stk_unf), 32'd0);
      reg_thr = 3'd4;
      #1;
      check("t4_keep", 32'(stk_unf), 32'd1);
      stk_op(1, 1'b1, 1'b0, 1'b1);
      check("setwin_ovf", 32'(stk_ovf), 32'd1);
      probe(1);
      probe(4);

      reg_thr = 3'd7; variation = 1'b1;
      reg_dst = 2'd2; dst = 8'h99; reg_we = 1'b1;
      tick();
      variation = 1'b0; reg_we = 1'b0;
      ma[7] = 8'h38;
      probe(7);

      fork_from = 3'd2; fork_to = 3'd5; fork_req = 1'b1;
      tick();
      fork_req = 1'b0;
      tick();
      check("mid_busy", 32'(busy), 32'd1);
      RST_n = 1'b0;
      tick();
      check("mid_rst_done", 32'(fork_done), 32'd0);
      RST_n = 1'b1;
      sweep(1'b1);
      check("post_done", 32'(fork_done), 32'd0);
      for (int t = 0; t < NT; t++) probe(t);
      reg_thr = 3'd1;
      #1;
      check("reinit_ovf", 32'(stk_ovf), 32'd0);
      reg_thr = 3'd4;
      #1;
      check("reinit_unf", 32'(stk_unf), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
